dmux_nway_reg: RTL
==================

# dmux_nway_reg

Parametrised, registered N-way demultiplexer with per-channel valid/ready handshakes and an optional broadcast mode. A single input word is steered by `sel` into one of 2^SEL_BITS one-entry output registers, or copied into all of them when `bcast` is set. Each output channel holds its word until the downstream consumer takes it. It is the sequential successor to the combinational 4-way demux and sits between a single producer, such as the CPU data path, and multiple memory-mapped consumers.

## Interface
- WIDTH, 16, data word width in bits (≥1)
- SEL_BITS, 2, select width; channel count N = 2^SEL_BITS (≥1)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer offers `in` this cycle
- in_ready  output  1  block accepts `in` this cycle (combinational)
- in  input  WIDTH  data word
- sel  input  SEL_BITS  target channel; ignored when `bcast`=1
- bcast  input  1  broadcast: write the word to every channel
- out_valid  output  N  per-channel holds a word; bit k = channel k
- out_ready  input  N  per-channel consumer takes the word
- out  output  N*WIDTH  channel k data at bits [k*WIDTH +: WIDTH]

## Operation
- Each channel k holds a 1-entry register: data_k (WIDTH bits) and valid_k.
- free_k = ~valid_k | out_ready[k], meaning the channel is empty or is draining this cycle.
- in_ready:
  - `bcast`=0: in_ready = free_sel.
  - `bcast`=1: in_ready = AND of free_k over all k.
- Accept = in_valid & in_ready. On accept:
  - `bcast`=0: data_sel ← in and valid_sel ← 1.
  - `bcast`=1: every data_k ← in and every valid_k ← 1.
- Drain: for any channel with valid_k & out_ready[k] and no load this cycle, valid_k ← 0.
- Load and drain on the same channel in the same cycle: valid stays 1 and data takes the new word.
- data_k is held when not loaded, including after a drain. `out` is not zeroed when valid_k=0, so consumers must qualify it with out_valid.
- out_ready[k] while valid_k=0 has no effect.
- in_valid=0 makes `in`, `sel` and `bcast` don't-care. The block does not require inputs to stay stable while in_valid is held and in_ready is low; each cycle is evaluated independently.
- Channels operate independently. A stalled channel blocks only transfers that target it, or every transfer while `bcast`=1.
- Reset (async assert, synchronous deassert by the system): all valid_k=0 and all data_k=0, so out_valid=0 and out=0. While rst_n=0, in_ready=1, because all channels are free, but no transfer is performed. A reset asserted mid-transfer discards all held words.

## Timing
- Latency is 1 cycle: a word accepted at edge t appears on out/out_valid after edge t.
- Full throughput: one accept per cycle to a channel whose consumer holds out_ready=1 continuously.
- in_ready depends combinationally on sel, bcast, valid_k and out_ready. There is no combinational path from in_valid or in to any output.
- All state updates occur on the rising edge of clk; reset acts immediately on rst_n falling.

## Test plan
- Reset, then in=16'h00AA, sel=2, in_valid=1 for 1 cycle, all out_ready=0 -> next cycle out_valid=4'b0100, channel 2 data=16'h00AA, other channels 0, in_ready with sel=2 reads 0.
- Channel 1 full and stalled (out_ready=0); offer sel=1 then sel=3 with in=16'h1234 -> sel=1 is refused (in_ready=0, data unchanged); sel=3 is accepted and out_valid becomes 4'b1010.
- Channel 0 full with 16'h0001 and out_ready[0]=1, same cycle in=16'h0002, sel=0 -> in_ready=1, out_valid[0] stays 1 and data becomes 16'h0002. The next cycle, with in_valid=0, clears valid[0]; data holds 16'h0002.
- bcast=1, in=16'hBEEF, channel 3 full and stalled -> in_ready=0 and nothing is written. After out_ready[3]=1 the broadcast is accepted: out_valid=4'b1111 and all channels hold 16'hBEEF.
- Stream 8 words 0..7 with sel=k mod 4 and all out_ready=1 -> 8 accepts in 8 consecutive cycles, each channel sees its words in order, in_ready stays 1.
- Assert rst_n=0 mid-cycle while channels 0 and 2 are full -> out_valid=0 and out=0 immediately, without waiting for a clk edge. After release, the first accept behaves as in the first scenario.

Source files
------------

// File: rtl/dmux_nway_reg.sv
// Registered N-way demux: one input word steered by sel (or broadcast) into per-channel one-entry registers.
// Latency 1 cycle; in_ready drops when the target channel (or any channel on broadcast) is full and not draining.
module dmux_nway_reg #(
  parameter int WIDTH    = 16,
  parameter int SEL_BITS = 2,
  localparam int N       = 1 << SEL_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in,
  input  logic [SEL_BITS-1:0]   sel,
  input  logic                  bcast,
  output logic [N-1:0]          out_valid,
  input  logic [N-1:0]          out_ready,
  output logic [N*WIDTH-1:0]    out
);

  logic [N-1:0]            valid_q, valid_d;
  logic [N-1:0][WIDTH-1:0] data_q, data_d;
  logic [N-1:0]            free;
  logic [N-1:0]            load;
  logic                    accept;

  always_comb begin
    free     = ~valid_q | out_ready;
    in_ready = bcast ? (&free) : free[sel];
    accept   = in_valid & in_ready;

    load = '0;
    if (accept) begin
      if (bcast) load = '1;
      else       load[sel] = 1'b1;
    end

    // A load wins over a same-cycle drain, so the channel stays valid with the new word.
    valid_d = (valid_q & ~out_ready) | load;
    data_d  = data_q;
    for (int k = 0; k < N; k++) begin
      if (load[k]) data_d[k] = in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out       = data_q;

endmodule
